instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Front end of the single-cycle RISC-V core: owns the PC, reads an instruction ROM and presents
//  {instr_o, pc_o} to the control unit / decoder. Consumes the decoder's branch decision
//  (PCSrc_i) and the extended immediate to redirect fetch. Synchronous ROM: 1-cycle refill bubble.
// PARAMETERS
//  ADDR_WIDTH      32       PC width; all PC arithmetic modulo 2**ADDR_WIDTH
//  INSTR_WIDTH     32       instruction word width
//  ROM_ADDR_WIDTH  8        log2(ROM depth in words); ROM index = pc[ROM_ADDR_WIDTH+1:2]
//  RESET_PC        32'h0    PC fetched after reset
//  ROM_FILE        "program.hex"  $readmemh image
// PORTS
//  clk_i         in   1            clock, rising edge
//  rst_i         in   1            synchronous reset, active-high
//  stall_i       in   1            consumer not ready; hold all state
//  PCSrc_i       in   1            take branch/jump for instruction on pc_o
//  ImmExt_i      in   ADDR_WIDTH   sign-extended offset, target = pc_o + ImmExt_i
//  instr_o       out  INSTR_WIDTH  instruction at pc_o
//  pc_o          out  ADDR_WIDTH   PC of instr_o
//  pc_plus4_o    out  ADDR_WIDTH   pc_o + 4 (combinational, for JAL/JALR link)
//  valid_o       out  1            instr_o/pc_o meaningful
//  misalign_o    out  1            misaligned redirect trapped (see CONFIGURATION)
// BEHAVIOUR
//  Regs: pc_f (next fetch addr), pc_o, instr_o, valid_o, state in {REFILL, RUN, HALT}.
//  Reset (rst_i=1 at edge, overrides all incl. stall_i): pc_f=RESET_PC, pc_o=0, instr_o=0,
//   valid_o=0, misalign_o=0, state=REFILL.
//  REFILL: instr_o<=rom[pc_f], pc_o<=pc_f, pc_f<=pc_f+4, valid_o<=1, ->RUN. stall_i ignored.
//  RUN, stall_i=1: all regs hold; PCSrc_i ignored (stall wins over simultaneous redirect).
//  RUN, stall_i=0, PCSrc_i=0: instr_o<=rom[pc_f], pc_o<=pc_f, pc_f<=pc_f+4; valid_o stays 1.
//  RUN, stall_i=0, PCSrc_i=1: pc_f<=target, valid_o<=0, ->REFILL (one-cycle bubble);
//   instr_o/pc_o hold stale values while valid_o=0.
//  PCSrc_i is sampled only when valid_o=1 and state=RUN.
//  Latency: reset release -> first valid_o=1 after 1 edge; redirect -> target valid after 2 edges.
//  Wrap: pc_f+4 and target wrap modulo 2**ADDR_WIDTH; ROM index wraps modulo ROM depth.
//  target[1:0]!=0: handled per CONFIGURATION.
//  HALT: valid_o=0, all regs hold, only rst_i exits.
// CONFIGURATION
//  FETCH_MISALIGN_TRAP_EN defined: redirect with target[1:0]!=0 -> misalign_o<=1 (sticky),
//   valid_o<=0, ->HALT; pc_f<=target unmodified for debug.
//  Not defined: target[1:0] forced to 2'b00, normal REFILL; misalign_o tied 0; HALT unreachable.
// TESTING
//  T1 reset: rom[0]=32'h00500093, RESET_PC=0; release rst_i -> cycle1 valid_o=0,
//     cycle2 valid_o=1, pc_o=0, instr_o=32'h00500093, pc_plus4_o=4.
//  T2 sequential: 4 cycles no stall -> pc_o 0,4,8,12, instr_o=rom[0..3], valid_o=1 throughout.
//  T3 stall: stall_i=1 for 3 cycles at pc_o=8 with PCSrc_i=1 -> pc_o/instr_o hold 8/rom[2],
//     no redirect; drop stall with PCSrc_i=0 -> pc_o=12.
//  T4 branch: pc_o=12, PCSrc_i=1, ImmExt_i=-8 -> next cycle valid_o=0, then pc_o=4, instr_o=rom[1].
//  T5 wrap: ROM_ADDR_WIDTH=2, run from 0 -> pc_o=16 gives instr_o=rom[0]; pc_o=32'hFFFFFFFC
//     advances to 0.
//  T6 misalign: pc_o=0, PCSrc_i=1, ImmExt_i=6 -> TRAP_EN: misalign_o=1, valid_o=0 until rst_i;
//     else pc_o=4 after bubble, misalign_o=0. Mid-refill rst_i -> reset values next edge.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, reads a synchronous instruction ROM, redirects on taken branches.
// Optional feature macro FETCH_MISALIGN_TRAP_EN: misaligned redirect targets halt fetch and raise misalign_o.
module instr_fetch_unit #(
    parameter int    ADDR_WIDTH     = 32,
    parameter int    INSTR_WIDTH    = 32,
    parameter int    ROM_ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
    parameter string ROM_FILE       = "program.hex"
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   stall_i,
    input  logic                   PCSrc_i,
    input  logic [ADDR_WIDTH-1:0]  ImmExt_i,
    output logic [INSTR_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0]  pc_o,
    output logic [ADDR_WIDTH-1:0]  pc_plus4_o,
    output logic                   valid_o,
    output logic                   misalign_o
);

    typedef enum logic [1:0] {REFILL, RUN, HALT} state_t;

    // The ROM image (ROM_FILE) is loaded by the surrounding environment into this array.
    logic [INSTR_WIDTH-1:0] rom [0:(2**ROM_ADDR_WIDTH)-1];

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   pc_f;
    logic [ADDR_WIDTH-1:0]   raw_target;
    logic [ADDR_WIDTH-1:0]   redirect_target;
    logic                    fetch_en;
    logic                    redirect_en;
    logic                    trap_en;

    assign raw_target = pc_o + ImmExt_i;
    assign pc_plus4_o = pc_o + ADDR_WIDTH'(4);

`ifdef FETCH_MISALIGN_TRAP_EN
    assign redirect_target = raw_target;
    assign trap_en         = redirect_en && (raw_target[1:0] != 2'b00);
`else
    assign redirect_target = raw_target & ~ADDR_WIDTH'(3);
    assign trap_en         = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= REFILL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            REFILL:  state_next = RUN;
            RUN: begin
                if (redirect_en) begin
                    state_next = trap_en ? HALT : REFILL;
                end
            end
            HALT:    state_next = HALT;
            default: state_next = REFILL;
        endcase
    end

    // Stall freezes RUN entirely, so it also masks a simultaneous redirect request.
    always_comb begin
        fetch_en    = 1'b0;
        redirect_en = 1'b0;
        case (state)
            REFILL: fetch_en = 1'b1;
            RUN: begin
                if (!stall_i) begin
                    fetch_en    = !PCSrc_i;
                    redirect_en = PCSrc_i && valid_o;
                end
            end
            default: begin
                fetch_en    = 1'b0;
                redirect_en = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_f    <= RESET_PC;
            pc_o    <= '0;
            instr_o <= '0;
            valid_o <= 1'b0;
        end else if (fetch_en) begin
            instr_o <= rom[pc_f[ROM_ADDR_WIDTH+1:2]];
            pc_o    <= pc_f;
            pc_f    <= pc_f + ADDR_WIDTH'(4);
            valid_o <= 1'b1;
        end else if (redirect_en) begin
            pc_f    <= redirect_target;
            valid_o <= 1'b0;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            misalign_o <= 1'b0;
        end else if (trap_en) begin
            misalign_o <= 1'b1;
        end
    end
`else
    assign misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit: reset, sequential fetch, stall, branch, wrap, misaligned redirect.
module tb_instr_fetch_unit;

    logic        clk_i;
    logic        rst_i;
    logic        stall_i;
    logic        PCSrc_i;
    logic [31:0] ImmExt_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        valid_o;
    logic        misalign_o;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] ROM0 = 32'h00500093;
    localparam logic [31:0] ROM1 = 32'h00100113;
    localparam logic [31:0] ROM2 = 32'h00200193;
    localparam logic [31:0] ROM3 = 32'h00300213;

    instr_fetch_unit #(
        .ADDR_WIDTH(32),
        .INSTR_WIDTH(32),
        .ROM_ADDR_WIDTH(2),
        .RESET_PC(32'h0),
        .ROM_FILE("program.hex")
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .stall_i(stall_i),
        .PCSrc_i(PCSrc_i),
        .ImmExt_i(ImmExt_i),
        .instr_o(instr_o),
        .pc_o(pc_o),
        .pc_plus4_o(pc_plus4_o),
        .valid_o(valid_o),
        .misalign_o(misalign_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Drive one cycle of inputs, let one rising edge pass, then settle before sampling.
    task automatic applyStimulus(input logic rst, input logic stall, input logic src,
                                 input logic [31:0] imm);
        rst_i    = rst;
        stall_i  = stall;
        PCSrc_i  = src;
        ImmExt_i = imm;
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    initial begin
        dut.rom[0] = ROM0;
        dut.rom[1] = ROM1;
        dut.rom[2] = ROM2;
        dut.rom[3] = ROM3;
        rst_i = 1'b1; stall_i = 1'b0; PCSrc_i = 1'b0; ImmExt_i = 32'h0;

        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("rst_valid", 32'(valid_o), 32'd0);
        checkOutput("rst_pc", pc_o, 32'h0);
        checkOutput("rst_instr", instr_o, 32'h0);
        checkOutput("rst_misalign", 32'(misalign_o), 32'd0);

        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("t1_valid", 32'(valid_o), 32'd1);
        checkOutput("t1_pc", pc_o, 32'h0);
        checkOutput("t1_instr", instr_o, ROM0);
        checkOutput("t1_pc4", pc_plus4_o, 32'h4);

        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("t2_pc4", pc_o, 32'h4);
        checkOutput("t2_instr1", instr_o, ROM1);
        checkOutput("t2_valid", 32'(valid_o), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("t2_pc8", pc_o, 32'h8);
        checkOutput("t2_instr2", instr_o, ROM2);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 32'h40);
            checkOutput("t3_hold_pc", pc_o, 32'h8);
            checkOutput("t3_hold_instr", instr_o, ROM2);
            checkOutput("t3_hold_valid", 32'(valid_o), 32'd1);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("t3_resume_pc", pc_o, 32'hC);
        checkOutput("t3_resume_instr", instr_o, ROM3);

        applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8);
        checkOutput("t4_bubble_valid", 32'(valid_o), 32'd0);
        checkOutput("t4_bubble_pc", pc_o, 32'hC);
        // Refill cycle ignores both stall and a redirect request.
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h40);
        checkOutput("t4_target_valid", 32'(valid_o), 32'd1);
        checkOutput("t4_target_pc", pc_o, 32'h4);
        checkOutput("t4_target_instr", instr_o, ROM1);

        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("t5_pc16", pc_o, 32'h10);
        checkOutput("t5_rom_wrap", instr_o, ROM0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFEC);
        checkOutput("t5_bubble_valid", 32'(valid_o), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("t5_top_pc", pc_o, 32'hFFFF_FFFC);
        checkOutput("t5_top_instr", instr_o, ROM3);
        checkOutput("t5_top_pc4", pc_plus4_o, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("t5_wrap_pc", pc_o, 32'h0);
        checkOutput("t5_wrap_instr", instr_o, ROM0);

        applyStimulus(1'b0, 1'b0, 1'b1, 32'h6);
        checkOutput("t6_bubble_valid", 32'(valid_o), 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
        checkOutput("t6_trap_flag", 32'(misalign_o), 32'd1);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
            checkOutput("t6_halt_valid", 32'(valid_o), 32'd0);
            checkOutput("t6_halt_flag", 32'(misalign_o), 32'd1);
            checkOutput("t6_halt_pc", pc_o, 32'h0);
        end
`else
        checkOutput("t6_no_flag", 32'(misalign_o), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("t6_aligned_valid", 32'(valid_o), 32'd1);
        checkOutput("t6_aligned_pc", pc_o, 32'h4);
        checkOutput("t6_aligned_instr", instr_o, ROM1);
        checkOutput("t6_aligned_flag", 32'(misalign_o), 32'd0);
`endif

        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("t6_reset_valid", 32'(valid_o), 32'd0);
        checkOutput("t6_reset_flag", 32'(misalign_o), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h8);
        checkOutput("mid_bubble_valid", 32'(valid_o), 32'd0);
        // Reset during the refill bubble must win over both the refill and a stall.
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("mid_rst_valid", 32'(valid_o), 32'd0);
        checkOutput("mid_rst_pc", pc_o, 32'h0);
        checkOutput("mid_rst_instr", instr_o, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("mid_restart_pc", pc_o, 32'h0);
        checkOutput("mid_restart_instr", instr_o, ROM0);
        checkOutput("mid_restart_valid", 32'(valid_o), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
